keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner_pkg.sv | 38 +++
 rtl/keypad_scanner_if.sv | 24 ++
 rtl/keypad_scanner_debounce.sv | 123 ++++++++++++
 rtl/keypad_scanner.sv | 83 ++++++++
 tb/tb_keypad_scanner.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   state_t      : debounce FSM states
//   cand_class_t : per-scan classification of the 16-bit key snapshot
//   ROW_PATTERN  : active-low one-cold row strobe for each row index
//   classify()   : NONE / SINGLE / MULTI from a completed snapshot
//   first_set()  : index of the highest set snapshot bit, {row, col}
package keypad_pkg;

   localparam int unsigned NUM_ROWS = 4;
   localparam int unsigned NUM_COLS = 4;
   localparam int unsigned SNAP_W   = NUM_ROWS * NUM_COLS;

   typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;
   typedef enum logic [1:0] {NONE, SINGLE, MULTI} cand_class_t;

   localparam logic [3:0] ROW_PATTERN [NUM_ROWS] =
      '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   function automatic cand_class_t classify(input logic [SNAP_W-1:0] snap);
      int ones;
      ones = $countones(snap);
      if (ones == 0)
         return NONE;
      else if (ones == 1)
         return SINGLE;
      return MULTI;
   endfunction

   // Snapshot bit index equals {row_idx, col_idx}, so the bit position is the key code.
   function automatic logic [3:0] first_set(input logic [SNAP_W-1:0] snap);
      logic [3:0] code;
      code = '0;
      for (int unsigned i = 0; i < SNAP_W; i++)
         if (snap[i]) code = 4'(i);
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the key event outputs.
//   col_in    : keypad columns, active-low, asynchronous
//   row_out   : active-low one-cold row strobe
//   key_code  : {row_idx, col_idx} of the last accepted key
//   key_valid : one-cycle pulse per accepted press
//   key_held  : high while the accepted key is considered pressed
// master = scanner side, slave = keypad / consumer side.
interface keypad_scanner_if;
   logic [3:0] col_in;
   logic [3:0] row_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  col_in,
      output row_out, key_code, key_valid, key_held
   );

   modport slave (
      output col_in,
      input  row_out, key_code, key_valid, key_held
   );
endinterface

// File: rtl/keypad_scanner_debounce.sv
// keypad_debounce: whole-scan debounce FSM for the keypad scanner.
//   clk, rst      : clock, synchronous active-high reset
//   i_scan_done   : high on the cycle a completed snapshot is evaluated
//   i_cand_class  : NONE / SINGLE / MULTI for that snapshot
//   i_cand_code   : key code when i_cand_class is SINGLE
//   o_key_code    : accepted key, held until the next accepted press
//   o_key_valid   : one-cycle pulse on acceptance
//   o_key_held    : level, high from acceptance until release completes
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_scan_done,
   input  cand_class_t i_cand_class,
   input  logic [3:0]  i_cand_code,
   output logic [3:0]  o_key_code,
   output logic        o_key_valid,
   output logic        o_key_held
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

   state_t           r_state, w_state_nx;
   logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
   logic [3:0]       r_cand, w_cand_nx;
   logic [3:0]       r_key_code, w_key_code_nx;
   logic             r_key_valid, w_key_valid_nx;
   logic             r_key_held, w_key_held_nx;
   logic             w_single, w_same_cand, w_same_key;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_cand      <= '0;
         r_key_code  <= '0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_cand      <= w_cand_nx;
         r_key_code  <= w_key_code_nx;
         r_key_valid <= w_key_valid_nx;
         r_key_held  <= w_key_held_nx;
      end
   end

   always_comb begin
      w_state_nx     = r_state;
      w_cnt_nx       = r_cnt;
      w_cand_nx      = r_cand;
      w_key_code_nx  = r_key_code;
      w_key_valid_nx = 1'b0;
      w_key_held_nx  = r_key_held;
      w_cnt_inc      = r_cnt + 1'b1;
      w_single       = (i_cand_class == SINGLE);
      w_same_cand    = w_single && (i_cand_code == r_cand);
      w_same_key     = w_single && (i_cand_code == r_key_code);

      if (i_scan_done) begin
         unique case (r_state)
            IDLE: begin
               if (w_single) begin
                  w_state_nx = CONFIRM;
                  w_cand_nx  = i_cand_code;
                  w_cnt_nx   = CNT_W'(1);
               end
            end
            CONFIRM: begin
               if (w_same_cand) begin
                  w_cnt_nx = w_cnt_inc;
                  if (w_cnt_inc == CNT_DONE) begin
                     w_state_nx     = HELD;
                     w_key_code_nx  = r_cand;
                     w_key_valid_nx = 1'b1;
                     w_key_held_nx  = 1'b1;
                  end
               end else if (w_single) begin
                  w_cand_nx = i_cand_code;
                  w_cnt_nx  = CNT_W'(1);
               end else begin
                  w_state_nx = IDLE;
                  w_cnt_nx   = '0;
               end
            end
            HELD: begin
               if (!w_same_key) begin
                  w_state_nx = RELEASE;
                  w_cnt_nx   = CNT_W'(1);
               end
            end
            RELEASE: begin
               // Return to HELD on bounce without re-announcing the key.
               if (w_same_key) begin
                  w_state_nx = HELD;
                  w_cnt_nx   = CNT_DONE;
               end else begin
                  w_cnt_nx = w_cnt_inc;
                  if (w_cnt_inc == CNT_DONE) begin
                     w_state_nx    = IDLE;
                     w_cnt_nx      = '0;
                     w_key_held_nx = 1'b0;
                  end
               end
            end
            default: begin
               w_state_nx = IDLE;
               w_cnt_nx   = '0;
            end
         endcase
      end
   end

   assign o_key_code  = r_key_code;
   assign o_key_valid = r_key_valid;
   assign o_key_held  = r_key_held;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with whole-scan debounce.
//   clk, rst : clock, synchronous active-high reset
//   kp       : keypad_scanner_if.master
//              col_in (in), row_out, key_code, key_valid, key_held (out)
// Rows are strobed for SCAN_DIV cycles each; the synchronized columns are
// sampled on the last slot of every row into a 16-bit snapshot, which is
// classified and handed to keypad_debounce one cycle after row 3 is sampled.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic             clk,
   input  logic             rst,
   keypad_scanner_if.master kp
);

   localparam int unsigned SLOT_W = $clog2(SCAN_DIV);

   logic [NUM_COLS-1:0] r_sync1, r_sync2;
   logic [SLOT_W-1:0]   r_slot;
   logic [1:0]          r_row_idx;
   logic [SNAP_W-1:0]   r_snap;
   logic                r_scan_done;
   logic                w_sample;
   cand_class_t         w_cand_class;
   logic [3:0]          w_cand_code;
   logic [3:0]          w_key_code;
   logic                w_key_valid, w_key_held;

   assign w_sample = (r_slot == SLOT_W'(SCAN_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1     <= '1;
         r_sync2     <= '1;
         r_slot      <= '0;
         r_row_idx   <= '0;
         r_snap      <= '0;
         r_scan_done <= 1'b0;
      end else begin
         r_sync1     <= kp.col_in;
         r_sync2     <= r_sync1;
         r_scan_done <= w_sample && (r_row_idx == 2'd3);
         // Evaluation happens on slot 0, never on a sample slot, so the
         // clear below cannot collide with a snapshot write.
         if (r_scan_done)
            r_snap <= '0;
         if (w_sample) begin
            r_slot    <= '0;
            r_row_idx <= r_row_idx + 2'd1;
            r_snap[{r_row_idx, 2'b00} +: NUM_COLS] <= ~r_sync2;
         end else begin
            r_slot <= r_slot + 1'b1;
         end
      end
   end

   always_comb begin
      w_cand_class = classify(r_snap);
      w_cand_code  = first_set(r_snap);
   end

   keypad_debounce #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) u_debounce (
      .clk          (clk),
      .rst          (rst),
      .i_scan_done  (r_scan_done),
      .i_cand_class (w_cand_class),
      .i_cand_code  (w_cand_code),
      .o_key_code   (w_key_code),
      .o_key_valid  (w_key_valid),
      .o_key_held   (w_key_held)
   );

   assign kp.row_out   = ROW_PATTERN[r_row_idx];
   assign kp.key_code  = w_key_code;
   assign kp.key_valid = w_key_valid;
   assign kp.key_held  = w_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4,
// DEBOUNCE_SCANS=3 (one scan = 16 cycles). A keypad model pulls a column low
// while its row is strobed and the key is pressed. Expected key events
// (code + cycle of the key_valid pulse) are queued as stimulus is applied and
// matched against events captured from the DUT.
module tb_keypad_scanner;

   typedef struct {
      logic [3:0]  code;
      int unsigned cyc;
   } ev_t;

   logic        clk;
   logic        rst;
   logic [15:0] pressed;
   int unsigned cyc;
   int          checks;
   int          errors;
   ev_t         exp_q[$];
   ev_t         obs_q[$];
   int          rd_idx;

   keypad_scanner_if kif ();

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      kif.col_in = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4 + c] && !kif.row_out[r])
               kif.col_in[c] = 1'b0;
   end

   always @(negedge clk)
      if (kif.key_valid === 1'b1)
         obs_q.push_back('{code: kif.key_code, cyc: cyc});

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_pulses(input string tag);
      ev_t o, e;
      #1;
      while (rd_idx < obs_q.size()) begin
         o = obs_q[rd_idx];
         rd_idx++;
         chk({tag, "_unexpected_valid"}, 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_code"}, 32'(o.code), 32'(e.code));
            chk({tag, "_cycle"}, o.cyc, e.cyc);
         end
      end
      chk({tag, "_missing_valid"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // Stop at the negedge inside slot 0 of row 0 (first cycle of a scan).
   task automatic to_scan_start;
      logic [3:0] prev;
      int k;
      prev = kif.row_out;
      for (k = 0; k < 64; k++) begin
         @(negedge clk);
         if (prev == 4'b0111 && kif.row_out == 4'b1110) break;
         prev = kif.row_out;
      end
      chk("scan_align_timeout", 32'(k < 64), 32'd1);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [3:0]  rows [4];
      int          held_hi;
      int          held_lo;
      int unsigned n0;
      rows    = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      checks  = 0;
      errors  = 0;
      rd_idx  = 0;
      rst     = 1'b1;
      pressed = '0;

      // 1. Reset values, row rotation, quiet keypad
      wait_n(3);
      chk("rst_row_out",   32'(kif.row_out),   32'hE);
      chk("rst_key_code",  32'(kif.key_code),  32'h0);
      chk("rst_key_valid", 32'(kif.key_valid), 32'h0);
      chk("rst_key_held",  32'(kif.key_held),  32'h0);
      rst = 1'b0;
      chk("row_rot_0", 32'(kif.row_out), 32'(rows[0]));
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         chk($sformatf("row_rot_%0d", j), 32'(kif.row_out), 32'(rows[(j / 4) % 4]));
      end
      held_hi = 0;
      for (int j = 0; j < 184; j++) begin
         @(negedge clk);
         if (kif.key_held !== 1'b0) held_hi++;
      end
      chk("idle_held_cycles", 32'(held_hi), 32'd0);
      check_pulses("idle");

      // 2. Key (2,1) held for 10 scans, then released
      to_scan_start();
      pressed = 16'(1) << 9;
      n0 = cyc;
      exp_q.push_back('{code: 4'h9, cyc: n0 + 49});
      wait_n(48);
      chk("k9_held_before", 32'(kif.key_held), 32'd0);
      wait_n(2);
      chk("k9_held_after", 32'(kif.key_held), 32'd1);
      wait_n(110);
      pressed = '0;
      wait_n(47);
      chk("k9_release_still_held", 32'(kif.key_held), 32'd1);
      wait_n(3);
      chk("k9_release_dropped", 32'(kif.key_held), 32'd0);
      chk("k9_code_kept", 32'(kif.key_code), 32'h9);
      check_pulses("k9");

      // 3. Key (0,3) bouncing every scan
      to_scan_start();
      held_hi = 0;
      for (int s = 0; s < 12; s++) begin
         pressed = (s % 2 == 0) ? (16'(1) << 3) : 16'(0);
         for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (kif.key_held !== 1'b0) held_hi++;
         end
      end
      pressed = '0;
      wait_n(32);
      chk("bounce_held_cycles", 32'(held_hi), 32'd0);
      check_pulses("bounce");

      // 4. Two keys together, then one released
      to_scan_start();
      pressed = 16'(1) | (16'(1) << 15);
      wait_n(80);
      check_pulses("multi");
      pressed = 16'(1);
      n0 = cyc;
      exp_q.push_back('{code: 4'h0, cyc: n0 + 49});
      wait_n(50);
      chk("k0_held", 32'(kif.key_held), 32'd1);
      chk("k0_code", 32'(kif.key_code), 32'h0);
      check_pulses("k0");
      pressed = '0;
      wait_n(80);
      chk("k0_released", 32'(kif.key_held), 32'd0);

      // 5. Key (1,2) with a one-scan release glitch, then a full release
      to_scan_start();
      pressed = 16'(1) << 6;
      n0 = cyc;
      exp_q.push_back('{code: 4'h6, cyc: n0 + 49});
      wait_n(80);
      held_lo = 0;
      pressed = '0;
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         if (kif.key_held !== 1'b1) held_lo++;
      end
      pressed = 16'(1) << 6;
      for (int j = 0; j < 64; j++) begin
         @(negedge clk);
         if (kif.key_held !== 1'b1) held_lo++;
      end
      chk("k6_glitch_held_low_cycles", 32'(held_lo), 32'd0);
      pressed = '0;
      wait_n(47);
      chk("k6_release_still_held", 32'(kif.key_held), 32'd1);
      wait_n(3);
      chk("k6_release_dropped", 32'(kif.key_held), 32'd0);
      check_pulses("k6");

      // 6. Reset during CONFIRM (two matching scans seen)
      to_scan_start();
      pressed = 16'(1) << 12;
      wait_n(33);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_row_out",   32'(kif.row_out),   32'hE);
      chk("mid_rst_key_code",  32'(kif.key_code),  32'h0);
      chk("mid_rst_key_valid", 32'(kif.key_valid), 32'h0);
      chk("mid_rst_key_held",  32'(kif.key_held),  32'h0);
      n0 = cyc;
      exp_q.push_back('{code: 4'hC, cyc: n0 + 49});
      wait_n(48);
      chk("k12_held_before", 32'(kif.key_held), 32'd0);
      wait_n(2);
      chk("k12_held_after", 32'(kif.key_held), 32'd1);
      chk("k12_code", 32'(kif.key_code), 32'hC);
      pressed = '0;
      wait_n(100);
      chk("k12_released", 32'(kif.key_held), 32'd0);
      check_pulses("k12");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
